// File: rtl/motor_pkg.sv
// Shared types, constants and helpers for the drive-motor duty scheduler.
//   chan_state_t : per-channel ramp state (RUN = normal ramping, DEAD = zero-duty
//                  interval before a direction flip)
//   PER_MAX      : last count of the 11-bit PWM period counter
//   sat_mag()    : |signed speed| saturated to the commanded duty ceiling
package motor_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        DEAD = 1'b1
    } chan_state_t;

    localparam logic [10:0] PER_MAX = 11'h7FF;

    // Magnitude is formed in 13 bits so that -2048 maps to 2048 before saturation.
    function automatic logic [10:0] sat_mag(input logic signed [11:0] spd,
                                            input int max_duty);
        logic [12:0] abs_v;
        abs_v = spd[11] ? (~{spd[11], spd} + 13'd1) : {1'b0, spd};
        if (abs_v > 13'(max_duty))
            return 11'(max_duty);
        else
            return abs_v[10:0];
    endfunction

endpackage

// File: rtl/motor_ramp_chan.sv
// One motor channel: holds the target magnitude/direction, ramps the duty toward
// it once per PWM period, and inserts a zero-duty dead interval on reversal.
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : last cycle of the PWM period; duty/rev/state update on this edge
//   clr        : emergency stop; zeroes duty and targets on the next edge, keeps rev
//   cmd_load   : accepted speed command; captures spd into the target registers
//   spd        : signed speed target (two's complement)
//   duty, rev  : current duty and direction (1 = reverse)
//   at_tgt     : channel in RUN with duty and direction equal to target
module motor_ramp_chan
    import motor_pkg::*;
#(
    parameter int STEP         = 16,
    parameter int DEAD_PERIODS = 2,
    parameter int MAX_DUTY     = 2000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               clr,
    input  logic               cmd_load,
    input  logic signed [11:0] spd,
    output logic [10:0]        duty,
    output logic               rev,
    output logic               at_tgt
);

    localparam logic [10:0] STEP_W    = 11'(STEP);
    localparam logic [3:0]  DEAD_INIT = 4'(DEAD_PERIODS > 0 ? DEAD_PERIODS - 1 : 0);

    chan_state_t state_reg, state_next;
    logic [10:0] duty_reg, duty_next;
    logic [10:0] mag_reg, mag_next;
    logic        rev_reg, rev_next;
    logic        tgt_rev_reg, tgt_rev_next;
    logic [3:0]  dead_cnt_reg, dead_cnt_next;
    logic [10:0] gap, gap_step, down_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= RUN;
            duty_reg     <= '0;
            mag_reg      <= '0;
            rev_reg      <= 1'b0;
            tgt_rev_reg  <= 1'b0;
            dead_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            duty_reg     <= duty_next;
            mag_reg      <= mag_next;
            rev_reg      <= rev_next;
            tgt_rev_reg  <= tgt_rev_next;
            dead_cnt_reg <= dead_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        duty_next     = duty_reg;
        mag_next      = mag_reg;
        rev_next      = rev_reg;
        tgt_rev_next  = tgt_rev_reg;
        dead_cnt_next = dead_cnt_reg;

        // Step sizes clipped to the remaining distance so the ramp never overshoots.
        gap       = (mag_reg >= duty_reg) ? (mag_reg - duty_reg) : (duty_reg - mag_reg);
        gap_step  = (gap > STEP_W) ? STEP_W : gap;
        down_step = (duty_reg > STEP_W) ? STEP_W : duty_reg;

        if (cmd_load) begin
            mag_next     = sat_mag(spd, MAX_DUTY);
            tgt_rev_next = spd[11];
        end

        if (tick) begin
            case (state_reg)
                RUN: begin
                    if (tgt_rev_reg == rev_reg) begin
                        if (mag_reg >= duty_reg)
                            duty_next = duty_reg + gap_step;
                        else
                            duty_next = duty_reg - gap_step;
                    end else if (duty_reg != '0) begin
                        duty_next = duty_reg - down_step;
                    end else if (DEAD_PERIODS == 0) begin
                        rev_next = ~rev_reg;
                    end else begin
                        state_next    = DEAD;
                        dead_cnt_next = DEAD_INIT;
                    end
                end
                DEAD: begin
                    // The flip happens even if the target swung back meanwhile;
                    // a second reversal is then handled as a normal one.
                    duty_next = '0;
                    if (dead_cnt_reg != '0) begin
                        dead_cnt_next = dead_cnt_reg - 4'd1;
                    end else begin
                        rev_next   = ~rev_reg;
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end

        // Stop overrides everything, including the period alignment of duty changes.
        if (clr) begin
            state_next    = RUN;
            duty_next     = '0;
            mag_next      = '0;
            tgt_rev_next  = 1'b0;
            dead_cnt_next = '0;
        end
    end

    assign duty   = duty_reg;
    assign rev    = rev_reg;
    assign at_tgt = (state_reg == RUN) && (duty_reg == mag_reg) && (rev_reg == tgt_rev_reg);

endmodule

// File: rtl/motor_duty_sched.sv
// Duty-cycle scheduler for the left/right drive-motor PWM11 channels.
//   clk, rst_n          : clock, asynchronous active-low reset
//   cmd_vld / cmd_rdy   : speed command handshake (rdy low while stopped)
//   lft_spd, rght_spd   : signed 12-bit speed targets
//   estop               : emergency stop level; latches a stop on the next edge
//   estop_clr           : releases the latched stop when estop is low
//   lft_duty, rght_duty : 11-bit duties to the PWM11 pair
//   lft_rev, rght_rev   : direction, 1 = reverse
//   period_tick         : high in the last cycle of each 2048-cycle PWM period
//   settled             : both channels at target, no stop latched
module motor_duty_sched
    import motor_pkg::*;
#(
    parameter int STEP         = 16,
    parameter int DEAD_PERIODS = 2,
    parameter int MAX_DUTY     = 2000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_vld,
    output logic               cmd_rdy,
    input  logic signed [11:0] lft_spd,
    input  logic signed [11:0] rght_spd,
    input  logic               estop,
    input  logic               estop_clr,
    output logic [10:0]        lft_duty,
    output logic [10:0]        rght_duty,
    output logic               lft_rev,
    output logic               rght_rev,
    output logic               period_tick,
    output logic               settled
);

    logic [10:0]        per_cnt_reg;
    logic               stop_lat_reg, stop_lat_next;
    logic               cmd_load, chan_clr;
    logic signed [11:0] spd_arr  [2];
    logic [10:0]        duty_arr [2];
    logic [1:0]         rev_vec, at_tgt_vec;

    // Runs in lockstep with the PWM11 counter, so duties committed on the tick
    // edge are seen by the PWM starting at count 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt_reg  <= '0;
            stop_lat_reg <= 1'b0;
        end else begin
            per_cnt_reg  <= per_cnt_reg + 11'd1;
            stop_lat_reg <= stop_lat_next;
        end
    end

    always_comb begin
        stop_lat_next = stop_lat_reg;
        if (estop)
            stop_lat_next = 1'b1;
        else if (estop_clr)
            stop_lat_next = 1'b0;
    end

    assign period_tick = (per_cnt_reg == PER_MAX);
    assign cmd_rdy     = ~(estop | stop_lat_reg);
    assign cmd_load    = cmd_vld & cmd_rdy;
    // Holding the channels cleared while latched keeps duty and targets at zero
    // until the stop is explicitly released.
    assign chan_clr    = estop | stop_lat_reg;

    assign spd_arr[0] = lft_spd;
    assign spd_arr[1] = rght_spd;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            motor_ramp_chan #(
                .STEP         (STEP),
                .DEAD_PERIODS (DEAD_PERIODS),
                .MAX_DUTY     (MAX_DUTY)
            ) u_chan (
                .clk      (clk),
                .rst_n    (rst_n),
                .tick     (period_tick),
                .clr      (chan_clr),
                .cmd_load (cmd_load),
                .spd      (spd_arr[gi]),
                .duty     (duty_arr[gi]),
                .rev      (rev_vec[gi]),
                .at_tgt   (at_tgt_vec[gi])
            );
        end
    endgenerate

    assign lft_duty  = duty_arr[0];
    assign rght_duty = duty_arr[1];
    assign lft_rev   = rev_vec[0];
    assign rght_rev  = rev_vec[1];
    assign settled   = ~stop_lat_reg & (&at_tgt_vec);

endmodule

// File: tb/tb_motor_duty_sched.sv
`timescale 1ns/1ps
// Bench for motor_duty_sched. Instance A uses the default tuning (STEP 16, two dead
// periods); instance B uses STEP 700 and no dead periods so that full-scale
// saturation and the stop sequence fit in a few PWM periods. Both run concurrently.
module tb_motor_duty_sched;

    typedef struct {
        bit load;
        int l_spd;
        int r_spd;
        int l_duty;
        int l_rev;
        int r_duty;
        int r_rev;
        int settled;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic a_cmd_vld = 1'b0, a_estop = 1'b0, a_estop_clr = 1'b0;
    logic signed [11:0] a_lft_spd = '0, a_rght_spd = '0;
    logic a_cmd_rdy, a_lft_rev, a_rght_rev, a_period_tick, a_settled;
    logic [10:0] a_lft_duty, a_rght_duty;

    logic b_cmd_vld = 1'b0, b_estop = 1'b0, b_estop_clr = 1'b0;
    logic signed [11:0] b_lft_spd = '0, b_rght_spd = '0;
    logic b_cmd_rdy, b_lft_rev, b_rght_rev, b_period_tick, b_settled;
    logic [10:0] b_lft_duty, b_rght_duty;

    int n_checks = 0;
    int n_fails  = 0;

    vec_t tbl_a [21];
    vec_t tbl_b [7];

    always #5 clk = ~clk;

    motor_duty_sched #(.STEP(16), .DEAD_PERIODS(2), .MAX_DUTY(2000)) dut_a (
        .clk(clk), .rst_n(rst_n), .cmd_vld(a_cmd_vld), .cmd_rdy(a_cmd_rdy),
        .lft_spd(a_lft_spd), .rght_spd(a_rght_spd), .estop(a_estop), .estop_clr(a_estop_clr),
        .lft_duty(a_lft_duty), .rght_duty(a_rght_duty), .lft_rev(a_lft_rev), .rght_rev(a_rght_rev),
        .period_tick(a_period_tick), .settled(a_settled)
    );

    motor_duty_sched #(.STEP(700), .DEAD_PERIODS(0), .MAX_DUTY(2000)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd_vld(b_cmd_vld), .cmd_rdy(b_cmd_rdy),
        .lft_spd(b_lft_spd), .rght_spd(b_rght_spd), .estop(b_estop), .estop_clr(b_estop_clr),
        .lft_duty(b_lft_duty), .rght_duty(b_rght_duty), .lft_rev(b_lft_rev), .rght_rev(b_rght_rev),
        .period_tick(b_period_tick), .settled(b_settled)
    );

    function automatic vec_t mk(input bit load, input int ls, input int rs, input int ld,
                                input int lr, input int rd, input int rr, input int st);
        vec_t v;
        v.load = load; v.l_spd = ls; v.r_spd = rs;
        v.l_duty = ld; v.l_rev = lr; v.r_duty = rd; v.r_rev = rr; v.settled = st;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input int d, input string tag, input int ld, input int lr,
                              input int rd, input int rr, input int st);
        int al, alr, ar, arr_v, ast;
        if (d == 0) begin
            al = a_lft_duty; alr = a_lft_rev; ar = a_rght_duty; arr_v = a_rght_rev; ast = a_settled;
        end else begin
            al = b_lft_duty; alr = b_lft_rev; ar = b_rght_duty; arr_v = b_rght_rev; ast = b_settled;
        end
        chk($sformatf("dut%0d %s lft_duty", d, tag), al, ld);
        chk($sformatf("dut%0d %s lft_rev", d, tag), alr, lr);
        chk($sformatf("dut%0d %s rght_duty", d, tag), ar, rd);
        chk($sformatf("dut%0d %s rght_rev", d, tag), arr_v, rr);
        chk($sformatf("dut%0d %s settled", d, tag), ast, st);
        $display("[%0t] dut%0d %s: lft=%0d rev=%0d rght=%0d rev=%0d settled=%0d",
                 $time, d, tag, al, alr, ar, arr_v, ast);
    endtask

    task automatic drive_cmd(input int d, input int l, input int r);
        @(negedge clk);
        if (d == 0) begin
            a_cmd_vld = 1'b1; a_lft_spd = 12'(l); a_rght_spd = 12'(r);
        end else begin
            b_cmd_vld = 1'b1; b_lft_spd = 12'(l); b_rght_spd = 12'(r);
        end
        @(negedge clk);
        if (d == 0) a_cmd_vld = 1'b0;
        else        b_cmd_vld = 1'b0;
    endtask

    // Returns #1 after the edge that ends the PWM period.
    task automatic wait_tick(input int d);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2100 && !seen; i++) begin
            @(negedge clk);
            seen = (d == 0) ? a_period_tick : b_period_tick;
        end
        n_checks++;
        if (!seen) begin
            n_fails++;
            $display("FAIL dut%0d tick_timeout: period_tick got 0 for 2100 cycles, required 1", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int d, input int idx, input vec_t v);
        if (v.load) drive_cmd(d, v.l_spd, v.r_spd);
        wait_tick(d);
        check_outs(d, $sformatf("vec%0d", idx), v.l_duty, v.l_rev, v.r_duty, v.r_rev, v.settled);
    endtask

    // Duty may only change on the edge that follows period_tick, or on an estop/reset edge.
    logic [10:0] mon_q [4] = '{default: '0};
    logic [10:0] mon_cur [4];
    logic        mon_tick_q [2] = '{default: 1'b0};
    logic        mon_estop_q [2] = '{default: 1'b0};
    logic        mon_rst_q = 1'b0;

    always @(posedge clk) begin
        mon_cur[0] = a_lft_duty; mon_cur[1] = a_rght_duty;
        mon_cur[2] = b_lft_duty; mon_cur[3] = b_rght_duty;
        for (int k = 0; k < 4; k++) begin
            if (mon_rst_q && rst_n && (mon_cur[k] != mon_q[k])) begin
                n_checks++;
                if (!mon_tick_q[k/2] && !mon_estop_q[k/2]) begin
                    n_fails++;
                    $display("FAIL duty_off_tick ch%0d: changed %0d->%0d, required change only after period_tick",
                             k, mon_q[k], mon_cur[k]);
                end
            end
            mon_q[k] = mon_cur[k];
        end
        mon_tick_q[0]  = a_period_tick; mon_tick_q[1]  = b_period_tick;
        mon_estop_q[0] = a_estop;       mon_estop_q[1] = b_estop;
        mon_rst_q      = rst_n;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Ramp up, reversal through DEAD, ramp in reverse (lft); rght held at +100.
        tbl_a[0]  = mk(1, 100, 100,  16, 0,  16, 0, 0);
        tbl_a[1]  = mk(0,   0,   0,  32, 0,  32, 0, 0);
        tbl_a[2]  = mk(0,   0,   0,  48, 0,  48, 0, 0);
        tbl_a[3]  = mk(0,   0,   0,  64, 0,  64, 0, 0);
        tbl_a[4]  = mk(0,   0,   0,  80, 0,  80, 0, 0);
        tbl_a[5]  = mk(0,   0,   0,  96, 0,  96, 0, 0);
        tbl_a[6]  = mk(0,   0,   0, 100, 0, 100, 0, 1);
        tbl_a[7]  = mk(1, -50, 100,  84, 0, 100, 0, 0);
        tbl_a[8]  = mk(0,   0,   0,  68, 0, 100, 0, 0);
        tbl_a[9]  = mk(0,   0,   0,  52, 0, 100, 0, 0);
        tbl_a[10] = mk(0,   0,   0,  36, 0, 100, 0, 0);
        tbl_a[11] = mk(0,   0,   0,  20, 0, 100, 0, 0);
        tbl_a[12] = mk(0,   0,   0,   4, 0, 100, 0, 0);
        tbl_a[13] = mk(0,   0,   0,   0, 0, 100, 0, 0);
        tbl_a[14] = mk(0,   0,   0,   0, 0, 100, 0, 0);
        tbl_a[15] = mk(0,   0,   0,   0, 0, 100, 0, 0);
        tbl_a[16] = mk(0,   0,   0,   0, 1, 100, 0, 0);
        tbl_a[17] = mk(0,   0,   0,  16, 1, 100, 0, 0);
        tbl_a[18] = mk(0,   0,   0,  32, 1, 100, 0, 0);
        tbl_a[19] = mk(0,   0,   0,  48, 1, 100, 0, 0);
        tbl_a[20] = mk(0,   0,   0,  50, 1, 100, 0, 1);
        // Saturation of +2047 and -2048 to 2000, immediate flip without dead periods.
        tbl_b[0]  = mk(1, 2047, -2048,  700, 0,    0, 1, 0);
        tbl_b[1]  = mk(0,    0,     0, 1400, 0,  700, 1, 0);
        tbl_b[2]  = mk(0,    0,     0, 2000, 0, 1400, 1, 0);
        tbl_b[3]  = mk(0,    0,     0, 2000, 0, 2000, 1, 1);
        tbl_b[4]  = mk(1,  500, -2000, 1300, 0, 2000, 1, 0);
        tbl_b[5]  = mk(0,    0,     0,  600, 0, 2000, 1, 0);
        tbl_b[6]  = mk(0,    0,     0,  500, 0, 2000, 1, 1);

        #1;
        check_outs(0, "in_reset", 0, 0, 0, 0, 1);
        chk("dut0 in_reset cmd_rdy", a_cmd_rdy, 1);
        chk("dut0 in_reset period_tick", a_period_tick, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        fork
            begin
                for (int i = 0; i < 21; i++) run_vec(0, i, tbl_a[i]);
                // Two commands in one period: only the later one is applied.
                drive_cmd(0, -60, 100);
                drive_cmd(0, -30, 90);
                wait_tick(0);
                check_outs(0, "b2b_tick1", 34, 1, 90, 0, 0);
                wait_tick(0);
                check_outs(0, "b2b_tick2", 30, 1, 90, 0, 1);
            end
            begin
                for (int i = 0; i < 7; i++) run_vec(1, i, tbl_b[i]);
                repeat (700) @(posedge clk);
                // Stop mid-period with a simultaneous command that must be dropped.
                @(negedge clk);
                b_estop = 1'b1; b_cmd_vld = 1'b1; b_lft_spd = 12'sd300; b_rght_spd = 12'sd300;
                #1 chk("dut1 estop cmd_rdy comb", b_cmd_rdy, 0);
                @(posedge clk); #1;
                check_outs(1, "estop_hit", 0, 0, 0, 1, 0);
                chk("dut1 estop_hit cmd_rdy", b_cmd_rdy, 0);
                @(negedge clk);
                b_cmd_vld = 1'b0; b_estop_clr = 1'b1;
                @(negedge clk);
                b_estop_clr = 1'b0; b_estop = 1'b0;
                #1 chk("dut1 clr_with_estop ignored cmd_rdy", b_cmd_rdy, 0);
                repeat (3) @(negedge clk);
                chk("dut1 still_latched cmd_rdy", b_cmd_rdy, 0);
                b_estop_clr = 1'b1;
                @(negedge clk);
                b_estop_clr = 1'b0;
                #1 chk("dut1 released cmd_rdy", b_cmd_rdy, 1);
                check_outs(1, "released", 0, 0, 0, 1, 0);
                wait_tick(1);
                check_outs(1, "post_release", 0, 0, 0, 0, 1);
            end
        join

        // Reset in mid-operation returns everything at once.
        repeat (300) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outs(0, "reset_mid", 0, 0, 0, 0, 1);
        check_outs(1, "reset_mid", 0, 0, 0, 0, 1);
        chk("dut0 reset_mid cmd_rdy", a_cmd_rdy, 1);
        chk("dut0 reset_mid period_tick", a_period_tick, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
